// File: rtl/bridge_pkg.sv
// Shared types, constants and slot-decode helper for the system bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] BRIDGE_ERR_DATA = 32'h1234_ABCD;
    localparam int          HWINT_W         = 6;

    // Slot i covers [base + i*stride, base + i*stride + window).
    // Arithmetic is carried in 64 bits so a base beyond 2^32 is detected and never hits.
    function automatic logic hit(
        input logic [31:0] addr,
        input int unsigned i,
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] window
    );
        logic [63:0] slot_base;
        logic [63:0] slot_end;
        logic [63:0] addr_w;
        slot_base = {32'd0, base} + (64'(i) * {32'd0, stride});
        slot_end  = slot_base + {32'd0, window};
        addr_w    = {32'd0, addr};
        hit = (slot_base[63:32] == 32'd0) && (addr_w >= slot_base) && (addr_w < slot_end);
    endfunction

endpackage

// File: rtl/bridge_int_sync.sv
// Registers peripheral IRQs, synchronises ext_int through two flops, packs hw_int.
// Latency: dev_irq -> hw_int 1 cycle, ext_int -> hw_int 2 cycles.
// Backpressure: none; hw_int is a level vector, nothing is latched.
module bridge_int_sync
    import bridge_pkg::*;
#(
    parameter int NUM_DEV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DEV-1:0] dev_irq,
    input  logic               ext_int,
    output logic [HWINT_W-1:0] hw_int
);

    logic [NUM_DEV-1:0] irq_q, irq_d;
    logic               ext_meta_q, ext_meta_d;
    logic               ext_sync_q, ext_sync_d;

    // Next values: one stage for the synchronous IRQs, two-stage shift for ext_int.
    always_comb begin
        irq_d      = dev_irq;
        ext_meta_d = ext_int;
        ext_sync_d = ext_meta_q;
    end

    // Interrupt flops, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q      <= '0;
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
        end else begin
            irq_q      <= irq_d;
            ext_meta_q <= ext_meta_d;
            ext_sync_q <= ext_sync_d;
        end
    end

    // Pack: device IRQs in the low bits, external interrupt just above, zeros beyond.
    always_comb begin
        hw_int              = '0;
        hw_int[NUM_DEV-1:0] = irq_q;
        hw_int[NUM_DEV]     = ext_sync_q;
    end

endmodule

// File: rtl/sys_bridge_mc.sv
// CPU-to-peripheral bridge: address decode, registered req/ack transaction, IRQ aggregation.
// Latency: hit ack 2 cycles after req plus device wait states; decode miss ack after 1 cycle.
// Backpressure: pr_req ignored outside IDLE; BUSY waits on dev_rdy (bounded when BRIDGE_TIMEOUT_EN).
module sys_bridge_mc
    import bridge_pkg::*;
#(
    parameter int          NUM_DEV     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_7F00,
    parameter logic [31:0] DEV_STRIDE  = 32'h10,
    parameter logic [31:0] DEV_WINDOW  = 32'd12,
    parameter int          TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pr_req,
    input  logic [29:0]           pr_addr,
    input  logic                  pr_we,
    input  logic [31:0]           pr_wd,
    output logic                  pr_ack,
    output logic [31:0]           pr_rd,
    output logic                  pr_err,
    output logic [HWINT_W-1:0]    hw_int,
    output logic [29:0]           dev_addr,
    output logic [31:0]           dev_wd,
    output logic [NUM_DEV-1:0]    dev_sel,
    output logic [NUM_DEV-1:0]    dev_we,
    input  logic [32*NUM_DEV-1:0] dev_rd,
    input  logic [NUM_DEV-1:0]    dev_rdy,
    input  logic [NUM_DEV-1:0]    dev_irq,
    input  logic                  ext_int
);

    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    state_t           state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      wd_q, wd_d;
    logic             we_q, we_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic [31:0]      rd_q, rd_d;
    logic             err_q, err_d;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             sel_rdy;
    logic [31:0]      sel_rd;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC) < 4) ? 4 : $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Decode the incoming byte address; scanning downward lets the lowest hit index win.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (hit({pr_addr, 2'b00}, unsigned'(i), BASE_ADDR, DEV_STRIDE, DEV_WINDOW)) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    // Response mux from the latched slot.
    always_comb begin
        sel_rdy = dev_rdy[idx_q];
        sel_rd  = dev_rd[32*int'(idx_q) +: 32];
    end

    // Transaction FSM: next state and next values of the latched request/response fields.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        idx_d   = idx_q;
        first_d = 1'b0;
        rd_d    = rd_q;
        err_d   = err_q;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pr_req) begin
                    addr_d = pr_addr;
                    wd_d   = pr_wd;
                    we_d   = pr_we;
                    idx_d  = dec_idx;
                    if (dec_hit) begin
                        state_d = BUSY;
                        first_d = 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = RESP;
                        rd_d    = BRIDGE_ERR_DATA;
                        err_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                // A ready device wins over a timeout expiring in the same cycle.
                if (sel_rdy) begin
                    state_d = RESP;
                    rd_d    = we_q ? 32'd0 : sel_rd;
                    err_d   = 1'b0;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = RESP;
                    rd_d    = BRIDGE_ERR_DATA;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bridge state and latched fields; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            first_q <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Device-side strobes: select held through BUSY, write strobe on its first cycle only.
    always_comb begin
        dev_sel = '0;
        dev_we  = '0;
        if (state_q == BUSY) begin
            dev_sel[idx_q] = 1'b1;
            dev_we[idx_q]  = we_q & first_q;
        end
    end

    assign pr_ack   = (state_q == RESP);
    assign pr_rd    = rd_q;
    assign pr_err   = err_q;
    assign dev_addr = addr_q;
    assign dev_wd   = wd_q;

    bridge_int_sync #(
        .NUM_DEV(NUM_DEV)
    ) u_int_sync (
        .clk    (clk),
        .reset  (reset),
        .dev_irq(dev_irq),
        .ext_int(ext_int),
        .hw_int (hw_int)
    );

endmodule

// File: tb/tb_sys_bridge_mc.sv
// Randomised scoreboard bench for sys_bridge_mc with a window-arithmetic reference decode.
// Latency: checks ack cycle against request cycle for hits, misses and timeouts.
// Backpressure: device model inserts random wait states; stray requests are injected while busy.
module tb_sys_bridge_mc;
    import bridge_pkg::*;

    localparam int          NUM_DEV = 2;
    localparam logic [31:0] BASE    = 32'h0000_7F00;
    localparam logic [31:0] STRIDE  = 32'h10;
    localparam logic [31:0] WINDOW  = 32'd12;
    localparam int          TOC     = 15;
`ifdef BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pr_req;
    logic [29:0]           pr_addr;
    logic                  pr_we;
    logic [31:0]           pr_wd;
    logic                  pr_ack;
    logic [31:0]           pr_rd;
    logic                  pr_err;
    logic [HWINT_W-1:0]    hw_int;
    logic [29:0]           dev_addr;
    logic [31:0]           dev_wd;
    logic [NUM_DEV-1:0]    dev_sel;
    logic [NUM_DEV-1:0]    dev_we;
    logic [32*NUM_DEV-1:0] dev_rd;
    logic [NUM_DEV-1:0]    dev_rdy;
    logic [NUM_DEV-1:0]    dev_irq;
    logic                  ext_int;

    always #5 clk = ~clk;

    sys_bridge_mc #(.NUM_DEV(NUM_DEV)) dut (
        .clk(clk), .reset(reset), .pr_req(pr_req), .pr_addr(pr_addr), .pr_we(pr_we),
        .pr_wd(pr_wd), .pr_ack(pr_ack), .pr_rd(pr_rd), .pr_err(pr_err), .hw_int(hw_int),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_sel(dev_sel), .dev_we(dev_we),
        .dev_rd(dev_rd), .dev_rdy(dev_rdy), .dev_irq(dev_irq), .ext_int(ext_int)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          slot;
        logic [29:0] addr;
        logic [31:0] wd;
        int          sel_n;
        int          we_n;
        int unsigned req_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int          sel_cnt = 0;
    int          we_cnt = 0;
    int          dly[NUM_DEV];
    bit          int_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference decode from window arithmetic: offset from base, slot = offset/stride.
    function automatic int ref_slot(input logic [31:0] ba);
        longint off;
        if (ba < BASE) return -1;
        off = longint'(ba) - longint'(BASE);
        if (off / longint'(STRIDE) >= NUM_DEV) return -1;
        if (off % longint'(STRIDE) >= longint'(WINDOW)) return -1;
        return int'(off / longint'(STRIDE));
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Device model: selected slot answers after dly[] wait cycles; unselected rdy is noise.
    initial begin
        int k[NUM_DEV];
        dev_rdy = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_DEV; i++) begin
                if (dev_sel[i]) begin
                    k[i]++;
                    dev_rdy[i] = ((k[i] - 1) >= dly[i]);
                end else begin
                    k[i] = 0;
                    dev_rdy[i] = 1'($urandom % 2);
                end
            end
        end
    end

    // Interrupt stimulus and check: dev_irq one cycle late, ext_int two cycles late.
    initial begin
        logic [NUM_DEV-1:0] irq_p1;
        logic               ext_p1, ext_p2;
        irq_p1 = '0; ext_p1 = 1'b0; ext_p2 = 1'b0;
        dev_irq = '0; ext_int = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !int_en) begin
                dev_irq = '0; ext_int = 1'b0;
                irq_p1 = '0; ext_p1 = 1'b0; ext_p2 = 1'b0;
            end else begin
                check("hw_int", 64'(hw_int), 64'({ext_p2, irq_p1}));
                ext_p2  = ext_p1;
                dev_irq = NUM_DEV'($urandom);
                if ($urandom % 4 == 0) ext_int = ~ext_int;
                ext_p1  = ext_int;
                irq_p1  = dev_irq;
            end
        end
    end

    // Monitor: checks device-side strobes during BUSY and pops the scoreboard on each ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dev_sel != '0) begin
                    sel_cnt++;
                    if (sb.size() == 0) begin
                        check("sel_without_txn", 64'(dev_sel), 64'd0);
                    end else begin
                        check("dev_sel", 64'(dev_sel), (sb[0].slot < 0) ? 64'd0 : (64'd1 << sb[0].slot));
                        check("dev_addr", 64'(dev_addr), 64'(sb[0].addr));
                        check("dev_wd", 64'(dev_wd), 64'(sb[0].wd));
                    end
                end
                if (dev_we != '0) begin
                    we_cnt++;
                    check("dev_we_in_sel", 64'(dev_we & ~dev_sel), 64'd0);
                    check("dev_we_first_cycle", 64'(sel_cnt), 64'd1);
                end
                if (pr_ack) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 64'(pr_ack), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("pr_rd", 64'(pr_rd), 64'(e.rd));
                        check("pr_err", 64'(pr_err), 64'(e.err));
                        check("ack_latency", 64'(cyc - e.req_cyc), 64'(e.lat));
                        check("sel_cycles", 64'(sel_cnt), 64'(e.sel_n));
                        check("we_pulses", 64'(we_cnt), 64'(e.we_n));
                    end
                    sel_cnt = 0;
                    we_cnt  = 0;
                end
            end
        end
    end

    // Issue one request at a negedge, push its expectation, wait up to wait_max cycles for ack.
    task automatic issue(input logic [31:0] ba, input logic we, input logic [31:0] wd,
                         input logic [31:0] rdv, input int delay, input bit noise,
                         input int wait_max, input bit expect_ack);
        exp_t e;
        int   s;
        bit   got;
        logic [31:0] r;
        s = ref_slot(ba);
        e.slot = s; e.addr = ba[31:2]; e.wd = wd; e.req_cyc = cyc;
        if (s < 0) begin
            e.rd = BRIDGE_ERR_DATA; e.err = 1'b1; e.lat = 1; e.sel_n = 0; e.we_n = 0;
        end else if (TO_EN && delay >= TOC) begin
            e.rd = BRIDGE_ERR_DATA; e.err = 1'b1; e.lat = 1 + TOC; e.sel_n = TOC; e.we_n = int'(we);
        end else begin
            e.rd = we ? 32'd0 : rdv; e.err = 1'b0; e.lat = 2 + delay;
            e.sel_n = delay + 1; e.we_n = int'(we);
        end
        for (int i = 0; i < NUM_DEV; i++) dev_rd[32*i +: 32] = $urandom;
        if (s >= 0) begin
            dly[s] = delay;
            dev_rd[32*s +: 32] = rdv;
        end
        pr_addr = ba[31:2]; pr_we = we; pr_wd = wd; pr_req = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        pr_req = 1'b0;
        got = 1'b0;
        for (int n = 0; n < wait_max && !got; n++) begin
            if (pr_ack) begin
                got = 1'b1;
            end else begin
                if (noise && dev_sel != '0 && ($urandom % 3 == 0)) begin
                    r = $urandom;
                    pr_addr = BASE[31:2] + 30'(r % 3);
                    pr_we = r[31]; pr_wd = $urandom; pr_req = 1'b1;
                end else begin
                    pr_req = 1'b0;
                end
                @(negedge clk);
            end
        end
        pr_req = 1'b0;
        check("ack_seen", 64'(got), 64'(expect_ack));
        if (got) begin
            @(negedge clk);
            check("ack_one_cycle", 64'(pr_ack), 64'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pr_ack"}, 64'(pr_ack), 64'd0);
        check({tag, "_pr_rd"}, 64'(pr_rd), 64'd0);
        check({tag, "_pr_err"}, 64'(pr_err), 64'd0);
        check({tag, "_hw_int"}, 64'(hw_int), 64'd0);
        check({tag, "_dev_addr"}, 64'(dev_addr), 64'd0);
        check({tag, "_dev_wd"}, 64'(dev_wd), 64'd0);
        check({tag, "_dev_sel"}, 64'(dev_sel), 64'd0);
        check({tag, "_dev_we"}, 64'(dev_we), 64'd0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        int_en = 1'b0;
        pr_req = 1'b0;
        sb.delete();
        sel_cnt = 0;
        we_cnt = 0;
        #1;
        check_zero_outputs("rst_async");
        repeat (2) @(negedge clk);
        check_zero_outputs("rst_hold");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        int_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ba, r;
        int          s;
        reset = 1'b1; pr_req = 1'b0; pr_addr = '0; pr_we = 1'b0; pr_wd = '0; dev_rd = '0;
        for (int i = 0; i < NUM_DEV; i++) dly[i] = 0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        int_en = 1'b1;

        // Directed cases from the block description.
        issue(32'h7F04, 1'b0, 32'd0, 32'hA5A5_0001, 0, 1'b0, 50, 1'b1);
        issue(32'h7F14, 1'b1, 32'h0000_00FF, 32'hDEAD_BEEF, 3, 1'b0, 50, 1'b1);
        issue(32'h7F0C, 1'b0, 32'd0, 32'h0, 0, 1'b0, 50, 1'b1);
        issue(32'h8000, 1'b0, 32'd0, 32'h0, 0, 1'b0, 50, 1'b1);
        issue(32'h7EFC, 1'b1, 32'h55, 32'h0, 0, 1'b0, 50, 1'b1);
        issue(32'h7F08, 1'b0, 32'd0, 32'h0BAD_F00D, 14, 1'b0, 50, 1'b1);

        // Randomised mix of hits, window gaps, out-of-range slots and far addresses.
        for (int t = 0; t < 150; t++) begin
            r = $urandom;
            case (r % 6)
                0, 1, 2: begin
                    s  = int'($urandom % NUM_DEV);
                    ba = BASE + 32'(s) * STRIDE + 32'd4 * ($urandom % (WINDOW / 4));
                end
                3: ba = BASE + ($urandom % (NUM_DEV + 1)) * STRIDE + WINDOW
                        + 32'd4 * ($urandom % ((STRIDE - WINDOW) / 4));
                4: ba = BASE - 32'd4 * (1 + $urandom % 4);
                default: ba = $urandom & 32'hFFFF_FFFC;
            endcase
            issue(ba, 1'($urandom % 2), $urandom, $urandom, int'($urandom % 7), 1'b1, 50, 1'b1);
        end

        // Slot 0 never ready: aborts after the timeout, or hangs until reset.
        if (TO_EN) begin
            issue(32'h7F00, 1'($urandom % 2), $urandom, $urandom, 1000, 1'b0, 50, 1'b1);
        end else begin
            issue(32'h7F00, 1'b0, 32'd0, 32'h1111_2222, 1000, 1'b0, 100, 1'b0);
            do_reset();
        end

        // Reset in the middle of BUSY, then a normal transaction.
        issue(32'h7F10, 1'b1, 32'hCAFE_0001, 32'h0, 50, 1'b0, 3, 1'b0);
        do_reset();
        issue(32'h7F14, 1'b0, 32'd0, 32'h7777_8888, 2, 1'b0, 50, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
